// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serialising 64-bit data/fetch requests into eight byte beats on a 1024x8 RAM.
// Latency: grant at cycle 0, beats 1-8, ack cycle 9 (error ack cycle 1); requesters hold req until ack.
module mem_port_arbiter #(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [63:0]   d_addr_i,
    input  logic [63:0]   d_wdata_i,
    output logic          d_ack_o,
    output logic [63:0]   d_rdata_o,
    output logic          d_err_o,
    input  logic          f_req_i,
    input  logic [63:0]   f_addr_i,
    output logic          f_ack_o,
    output logic [63:0]   f_rdata_o,
    output logic          f_err_o,
    output logic [AW-1:0] ram_addr_o,
    output logic          ram_we_o,
    output logic [7:0]    ram_wdata_o,
    input  logic [7:0]    ram_rdata_i,
    output logic          busy_o
);
    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    localparam logic [63:0] LAST_OK = 64'(MEM_BYTES - 8);

    state_t        r_state;
    logic          r_prio_f;
    logic          r_port_f;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [63:0]   r_wdata;
    logic [63:0]   r_buf;
    logic [2:0]    r_beat;
    logic          r_d_ack;
    logic          r_d_err;
    logic [63:0]   r_d_rdata;
    logic          r_f_ack;
    logic          r_f_err;
    logic [63:0]   r_f_rdata;

    logic          w_any_req;
    logic          w_grant_f;
    logic [63:0]   w_gaddr;
    logic          w_gerr;
    logic          w_xfer;
    logic [5:0]    w_bit;
    logic [63:0]   w_rd_dat;

    // Ties go to the prio port; any grant hands priority to the other port.
    assign w_any_req = d_req_i || f_req_i;
    assign w_grant_f = f_req_i && (!d_req_i || r_prio_f);
    assign w_gaddr   = w_grant_f ? f_addr_i : d_addr_i;
    assign w_gerr    = w_gaddr > LAST_OK;
    assign w_xfer    = (r_state == XFER);
    assign w_bit     = {r_beat, 3'b000};
    // Byte 7 of the buffer is still clear on the last beat, so the live RAM byte is merged in.
    assign w_rd_dat  = r_we ? 64'd0 : (r_buf | {ram_rdata_i, 56'd0});

    assign ram_addr_o  = w_xfer ? r_addr + AW'(r_beat) : '0;
    assign ram_we_o    = w_xfer && r_we && !rst_i;
    assign ram_wdata_o = w_xfer ? r_wdata[w_bit +: 8] : 8'd0;
    assign busy_o      = (r_state != IDLE);

    assign d_ack_o   = r_d_ack;
    assign d_err_o   = r_d_err;
    assign d_rdata_o = r_d_rdata;
    assign f_ack_o   = r_f_ack;
    assign f_err_o   = r_f_err;
    assign f_rdata_o = r_f_rdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_prio_f  <= 1'b0;
            r_port_f  <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= 64'd0;
            r_buf     <= 64'd0;
            r_beat    <= 3'd0;
            r_d_ack   <= 1'b0;
            r_d_err   <= 1'b0;
            r_d_rdata <= 64'd0;
            r_f_ack   <= 1'b0;
            r_f_err   <= 1'b0;
            r_f_rdata <= 64'd0;
        end else begin
            r_d_ack <= 1'b0;
            r_f_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_port_f <= w_grant_f;
                        r_prio_f <= !w_grant_f;
                        r_addr   <= w_gaddr[AW-1:0];
                        r_we     <= !w_grant_f && d_we_i;
                        r_wdata  <= d_wdata_i;
                        r_beat   <= 3'd0;
                        r_buf    <= 64'd0;
                        if (w_gerr) begin
                            r_state <= RESP;
                            if (w_grant_f) begin
                                r_f_ack   <= 1'b1;
                                r_f_err   <= 1'b1;
                                r_f_rdata <= 64'd0;
                            end else begin
                                r_d_ack   <= 1'b1;
                                r_d_err   <= 1'b1;
                                r_d_rdata <= 64'd0;
                            end
                        end else begin
                            r_state <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (!r_we) begin
                        r_buf[w_bit +: 8] <= ram_rdata_i;
                    end
                    r_beat <= r_beat + 3'd1;
                    if (r_beat == 3'd7) begin
                        r_state <= RESP;
                        if (r_port_f) begin
                            r_f_ack   <= 1'b1;
                            r_f_err   <= 1'b0;
                            r_f_rdata <= w_rd_dat;
                        end else begin
                            r_d_ack   <= 1'b1;
                            r_d_err   <= 1'b0;
                            r_d_rdata <= w_rd_dat;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected responses, a negedge monitor checks acks.
module tb_mem_port_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        d_req_i;
    logic        d_we_i;
    logic [63:0] d_addr_i;
    logic [63:0] d_wdata_i;
    logic        d_ack_o;
    logic [63:0] d_rdata_o;
    logic        d_err_o;
    logic        f_req_i;
    logic [63:0] f_addr_i;
    logic        f_ack_o;
    logic [63:0] f_rdata_o;
    logic        f_err_o;
    logic [9:0]  ram_addr_o;
    logic        ram_we_o;
    logic [7:0]  ram_wdata_o;
    logic [7:0]  ram_rdata_i;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.MEM_BYTES(1024), .AW(10)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
        .f_req_i(f_req_i), .f_addr_i(f_addr_i),
        .f_ack_o(f_ack_o), .f_rdata_o(f_rdata_o), .f_err_o(f_err_o),
        .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i), .busy_o(busy_o)
    );

    logic [7:0] mem [0:1023];
    always @(posedge clk_i) if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
    assign ram_rdata_i = mem[ram_addr_o];

    int unsigned cyc = 0;
    int unsigned busy_cnt = 0;
    int unsigned we_cnt = 0;
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(negedge clk_i) begin
        if (busy_o)   busy_cnt <= busy_cnt + 1;
        if (ram_we_o) we_cnt   <= we_cnt + 1;
    end

    typedef struct {
        bit          port_f;
        int unsigned cyc;
        logic [63:0] rdata;
        bit          err;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Expected last values of each port's rdata, used to check the idle port holds.
    logic [63:0] last_d = 64'd0;
    logic [63:0] last_f = 64'd0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            last_d = 64'd0;
            last_f = 64'd0;
        end else if (d_ack_o || f_ack_o) begin
            exp_t e;
            chk("ack_exclusive", 64'(d_ack_o & f_ack_o), 64'd0);
            chk("ack_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ack_port", 64'(f_ack_o), 64'(e.port_f));
                chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                if (f_ack_o) begin
                    chk("f_rdata", f_rdata_o, e.rdata);
                    chk("f_err", 64'(f_err_o), 64'(e.err));
                    chk("d_rdata_hold", d_rdata_o, last_d);
                    last_f = e.rdata;
                end else begin
                    chk("d_rdata", d_rdata_o, e.rdata);
                    chk("d_err", 64'(d_err_o), 64'(e.err));
                    chk("f_rdata_hold", f_rdata_o, last_f);
                    last_d = e.rdata;
                end
            end
        end
    end

    task automatic wait_done(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk_i); #1;
            k++;
        end
        chk("ack_timeout_pending", 64'(sb.size()), 64'd0);
        sb.delete();
        d_req_i = 1'b0;
        f_req_i = 1'b0;
    endtask

    task automatic push_exp(input bit port_f, input int unsigned c, input logic [63:0] rd, input bit err);
        exp_t e;
        e.port_f = port_f;
        e.cyc    = c;
        e.rdata  = rd;
        e.err    = err;
        sb.push_back(e);
    endtask

    task automatic issue(input bit port_f, input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] exp_rd, input bit exp_err, input bit drop);
        int unsigned b0, w0;
        @(posedge clk_i); #1;
        b0 = busy_cnt;
        w0 = we_cnt;
        if (port_f) begin
            f_req_i  = 1'b1;
            f_addr_i = addr;
        end else begin
            d_req_i   = 1'b1;
            d_we_i    = we;
            d_addr_i  = addr;
            d_wdata_i = wdata;
        end
        push_exp(port_f, cyc + (exp_err ? 1 : 9), exp_rd, exp_err);
        if (drop) begin
            @(posedge clk_i); #1;
            d_req_i   = 1'b0;
            d_we_i    = 1'b1;
            d_addr_i  = 64'd500;
            d_wdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
        end
        wait_done(40);
        chk("busy_cycles", 64'(busy_cnt - b0), exp_err ? 64'd1 : 64'd9);
        chk("we_beats", 64'(we_cnt - w0), (we && !exp_err) ? 64'd8 : 64'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, 64'({d_ack_o, f_ack_o, d_err_o, f_err_o, ram_we_o, busy_o}), 64'd0);
        chk({tag, "_d_rdata"}, d_rdata_o, 64'd0);
        chk({tag, "_f_rdata"}, f_rdata_o, 64'd0);
        chk({tag, "_ram_bus"}, 64'({ram_addr_o, ram_wdata_o}), 64'd0);
    endtask

    initial begin
        int unsigned c0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        rst_i = 1'b1;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 64'd0; d_wdata_i = 64'd0;
        f_req_i = 1'b0; f_addr_i = 64'd0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_zero("reset");
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        issue(1'b0, 1'b1, 64'd16, 64'h1122_3344_5566_7788, 64'd0, 1'b0, 1'b0);
        chk("mem_16_23", {mem[23], mem[22], mem[21], mem[20], mem[19], mem[18], mem[17], mem[16]},
            64'h1122_3344_5566_7788);
        issue(1'b0, 1'b0, 64'd16, 64'd0, 64'h1122_3344_5566_7788, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 64'd0, 64'd0, 64'h0706_0504_0302_0100, 1'b0, 1'b0);

        issue(1'b0, 1'b0, 64'd1017, 64'd0, 64'd0, 1'b1, 1'b0);
        issue(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0, 1'b1, 1'b0);
        issue(1'b0, 1'b0, 64'd1016, 64'd0, 64'hFFFE_FDFC_FBFA_F9F8, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 64'd2000, 64'd0, 64'd0, 1'b1, 1'b0);

        issue(1'b0, 1'b0, 64'd16, 64'd0, 64'h1122_3344_5566_7788, 1'b0, 1'b1);

        // Reset during beat 4 of a write: beats 0-3 land, the rest never do.
        @(posedge clk_i); #1;
        c0 = cyc;
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 64'd32; d_wdata_i = 64'hAAAA_AAAA_AAAA_AAAA;
        while (cyc < c0 + 5) begin
            @(posedge clk_i); #1;
        end
        rst_i = 1'b1;
        d_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_zero("mid_rst");
        chk("mem_32_35", 64'({mem[35], mem[34], mem[33], mem[32]}), 64'hAAAA_AAAA);
        chk("mem_36_39", 64'({mem[39], mem[38], mem[37], mem[36]}), 64'h2726_2524);
        repeat (12) @(negedge clk_i);

        // Both ports held from reset: strict alternation starting with data.
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 64'd16;
        f_req_i = 1'b1; f_addr_i = 64'd0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        c0 = cyc;
        push_exp(1'b0, c0 + 9,  64'h1122_3344_5566_7788, 1'b0);
        push_exp(1'b1, c0 + 19, 64'h0706_0504_0302_0100, 1'b0);
        push_exp(1'b0, c0 + 29, 64'h1122_3344_5566_7788, 1'b0);
        push_exp(1'b1, c0 + 39, 64'h0706_0504_0302_0100, 1'b0);
        wait_done(60);
        repeat (12) @(negedge clk_i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
